uart_rx: RTL

- 8N1 UART receiver for the SharkBoard system, the receive end of the serial link whose transmit side the system already drives.
- Samples the asynchronous rxd line with 16x oversampling and majority voting, and reassembles bytes.
- Presents each byte to the system bus logic through a level-held available flag with a single-cycle acknowledge.
- Flags framing errors and overruns.

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with a 3-sample
// mid-bit majority vote, level-held rx_avail with one-cycle acknowledge.
module uart_rx #(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_ack,
   output logic       rx_error,
   output logic       rx_overrun,
   input  logic       err_clr,
   output logic       busy
);

   localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]       os_cnt_q, os_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [1:0]       samp_q, samp_d;
   logic             vote_q, vote_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_avail_q, rx_avail_d;
   logic             rx_error_q, rx_error_d;
   logic             rx_overrun_q, rx_overrun_d;
   logic             brk_q, brk_d;

   logic rxd_s;
   logic tick;
   logic vote_now;

   assign rxd_s    = sync2_q;
   assign tick     = (tick_cnt_q == TICK_LAST);
   // Third sample is taken live at tick 9 so STOP can act without waiting a tick.
   assign vote_now = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         tick_cnt_q   <= '0;
         os_cnt_q     <= 4'd0;
         bit_idx_q    <= 3'd0;
         samp_q       <= 2'b11;
         vote_q       <= 1'b1;
         shift_q      <= 8'h00;
         rx_data_q    <= 8'h00;
         rx_avail_q   <= 1'b0;
         rx_error_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         brk_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         tick_cnt_q   <= tick_cnt_d;
         os_cnt_q     <= os_cnt_d;
         bit_idx_q    <= bit_idx_d;
         samp_q       <= samp_d;
         vote_q       <= vote_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_avail_q   <= rx_avail_d;
         rx_error_q   <= rx_error_d;
         rx_overrun_q <= rx_overrun_d;
         brk_q        <= brk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!brk_q && !rxd_s) state_d = S_START;
         S_START: if (tick && os_cnt_q == 4'd15) state_d = vote_q ? S_IDLE : S_DATA;
         S_DATA:  if (tick && os_cnt_q == 4'd15 && bit_idx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (tick && os_cnt_q == 4'd9) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sync1_d      = uart_rxd;
      sync2_d      = sync1_q;
      tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
      os_cnt_d     = os_cnt_q;
      bit_idx_d    = bit_idx_q;
      samp_d       = samp_q;
      vote_d       = vote_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rx_avail_d   = rx_ack ? 1'b0 : rx_avail_q;
      rx_error_d   = err_clr ? 1'b0 : rx_error_q;
      rx_overrun_d = err_clr ? 1'b0 : rx_overrun_q;
      brk_d        = brk_q;

      if (state_q == S_IDLE) begin
         os_cnt_d = 4'd0;
         if (rxd_s) brk_d = 1'b0;
         // Phase-align the bit timing to the detected falling edge.
         if (state_d == S_START) tick_cnt_d = '0;
      end else if (tick) begin
         os_cnt_d = os_cnt_q + 4'd1;
         if (os_cnt_q == 4'd7) samp_d[0] = rxd_s;
         if (os_cnt_q == 4'd8) samp_d[1] = rxd_s;
         if (os_cnt_q == 4'd9) vote_d = vote_now;

         if (state_q == S_START && os_cnt_q == 4'd15) bit_idx_d = 3'd0;
         if (state_q == S_DATA && os_cnt_q == 4'd9) shift_d = {vote_now, shift_q[7:1]};
         if (state_q == S_DATA && os_cnt_q == 4'd15) bit_idx_d = bit_idx_q + 3'd1;

         if (state_q == S_STOP && os_cnt_q == 4'd9) begin
            if (vote_now) begin
               // An ack in the same cycle frees the holding register, so no overrun.
               if (rx_avail_q && !rx_ack) begin
                  rx_overrun_d = 1'b1;
               end else begin
                  rx_data_d  = shift_q;
                  rx_avail_d = 1'b1;
               end
            end else begin
               rx_error_d = 1'b1;
               brk_d      = 1'b1;
            end
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_avail   = rx_avail_q;
   assign rx_error   = rx_error_q;
   assign rx_overrun = rx_overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule
